// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer that drives one external 1-bit ALU slice LSB-first.
// Define SERIAL_ALU_FLAGS_EN to add the zero and ovf result flags.
module serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       aop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_aop,
`ifdef SERIAL_ALU_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [2:0] AopSub = 3'b110;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, r_sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;

  logic accept, last, illegal, arith;

  assign accept  = (state_q != StRun) && start;
  assign last    = (state_q == StRun) && (cnt_q == CNT_W'(WIDTH - 1));
  assign illegal = (slice_aop[1:0] == 2'b11);
  assign arith   = (slice_aop[1:0] == 2'b10);

  assign slice_a   = a_sh_q[0];
  assign slice_b   = b_sh_q[0];
  assign slice_cin = carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      r_sh_q    <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      slice_aop <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_sh_q    <= op_a;
            b_sh_q    <= op_b;
            r_sh_q    <= '0;
            cnt_q     <= '0;
            // Subtract is A + ~B + 1, so the first carry-in is the +1.
            carry_q   <= (aop == AopSub);
            slice_aop <= aop;
            busy      <= 1'b1;
            state_q   <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          r_sh_q  <= {slice_out, r_sh_q[WIDTH-1:1]};
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last) begin
            result    <= illegal ? '0 : {slice_out, r_sh_q[WIDTH-1:1]};
            carry_out <= arith & slice_cout;
            err       <= illegal;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  // Running OR of result bits seen so far; avoids a full-width compare.
  logic nz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      nz_q <= 1'b0;
    end else if (state_q == StRun) begin
      nz_q <= nz_q | slice_out;
      if (last) begin
        zero <= illegal | ~(nz_q | slice_out);
        // carry_q is the carry into the MSB during the final bit.
        ovf  <= arith & (carry_q ^ slice_cout);
      end
    end
  end
`else
  // Flags disabled: no extra state or ports.
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq with a behavioural 1-bit slice and
// an arithmetic reference model.
module tb_serial_alu_seq;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       aop = 3'b000;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy, done, err, carry_out;
  logic [WIDTH-1:0] result;
  logic             slice_a, slice_b, slice_cin;
  logic [2:0]       slice_aop;
  logic             slice_out, slice_cout;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             zero, ovf;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .aop        (aop),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .carry_out  (carry_out),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_aop  (slice_aop),
`ifdef SERIAL_ALU_FLAGS_EN
    .zero       (zero),
    .ovf        (ovf),
`endif
    .slice_out  (slice_out),
    .slice_cout (slice_cout)
  );

  // Behavioural 1-bit slice; logic ops drive cout=1 so carry_out forcing is visible.
  logic [1:0] s_sum;
  always_comb begin
    s_sum      = '0;
    slice_out  = 1'b1;
    slice_cout = 1'b1;
    case (slice_aop)
      3'b010: begin
        s_sum      = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_cin};
        slice_out  = s_sum[0];
        slice_cout = s_sum[1];
      end
      3'b110: begin
        s_sum      = {1'b0, slice_a} + {1'b0, ~slice_b} + {1'b0, slice_cin};
        slice_out  = s_sum[0];
        slice_cout = s_sum[1];
      end
      3'b000:  slice_out = slice_a;
      3'b001:  slice_out = ~slice_a;
      3'b100:  slice_out = ~(slice_a | slice_b);
      3'b101:  slice_out = ~(slice_a & slice_b);
      default: slice_out = 1'b1;
    endcase
  end

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             e;
    logic             z;
    logic             v;
  } exp_t;

  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t        m;
    logic [31:0] full;
    m = '0;
    case (op)
      3'b000: m.res = a;
      3'b001: m.res = ~a;
      3'b010: begin
        full  = 32'(a) + 32'(b);
        m.res = full[WIDTH-1:0];
        m.c   = full[WIDTH];
        m.v   = (a[WIDTH-1] == b[WIDTH-1]) && (m.res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b110: begin
        m.res = a - b;
        m.c   = (a >= b);
        m.v   = (a[WIDTH-1] != b[WIDTH-1]) && (m.res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b100: m.res = ~(a | b);
      3'b101: m.res = ~(a & b);
      default: m.e = 1'b1;
    endcase
    m.z = (m.res == '0);
    return m;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b);
    @(negedge clk);
    aop   = op;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the current sample point until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < int'(WIDTH) + 4) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_out(input string tag, input exp_t m);
    check_eq({tag, ".done"}, 32'(done), 32'd1);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".result"}, 32'(result), 32'(m.res));
    check_eq({tag, ".carry"}, 32'(carry_out), 32'(m.c));
    check_eq({tag, ".err"}, 32'(err), 32'(m.e));
`ifdef SERIAL_ALU_FLAGS_EN
    check_eq({tag, ".zero"}, 32'(zero), 32'(m.z));
    check_eq({tag, ".ovf"}, 32'(ovf), 32'(m.v));
`endif
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    int lat;
    start_op(op, a, b);
    start = 1'b0;
    op_a  = WIDTH'($urandom);
    op_b  = WIDTH'($urandom);
    check_eq({tag, ".busy_run"}, 32'(busy), 32'd1);
    check_eq({tag, ".slice_aop"}, 32'(slice_aop), 32'(op));
    wait_done(lat);
    check_eq({tag, ".latency"}, 32'(lat), 32'(WIDTH));
    check_out(tag, model(op, a, b));
    @(posedge clk);
    #1;
    check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    logic [2:0] rop;
    logic [WIDTH-1:0] ra, rb;

    #1;
    check_eq("reset.busy", 32'(busy), 32'd0);
    check_eq("reset.done", 32'(done), 32'd0);
    check_eq("reset.result", 32'(result), 32'd0);
    check_eq("reset.slice_aop", 32'(slice_aop), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_3c_0f", 3'b010, 8'h3C, 8'h0F);
    do_op("add_ff_01", 3'b010, 8'hFF, 8'h01);
    do_op("add_7f_01", 3'b010, 8'h7F, 8'h01);
    do_op("sub_05_07", 3'b110, 8'h05, 8'h07);
    do_op("sub_07_05", 3'b110, 8'h07, 8'h05);
    do_op("nand", 3'b101, 8'hF0, 8'hCC);
    do_op("nor", 3'b100, 8'hF0, 8'hCC);
    do_op("not", 3'b001, 8'hA5, 8'h00);
    do_op("mov", 3'b000, 8'h96, 8'h33);

    // start pulsed mid-run must be ignored
    start_op(3'b010, 8'h3C, 8'h0F);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aop   = 3'b110;
    op_a  = 8'h00;
    op_b  = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("ignore.slice_aop", 32'(slice_aop), 32'h2);
    wait_done(lat);
    check_eq("ignore.latency", 32'(lat + 3), 32'(WIDTH));
    check_out("ignore", model(3'b010, 8'h3C, 8'h0F));

    // start held through DONE re-accepts with no idle gap
    @(posedge clk);
    #1;
    start_op(3'b110, 8'h40, 8'h10);
    aop  = 3'b100;
    op_a = 8'h0A;
    op_b = 8'h50;
    wait_done(lat);
    check_out("b2b_first", model(3'b110, 8'h40, 8'h10));
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("b2b.busy", 32'(busy), 32'd1);
    check_eq("b2b.done", 32'(done), 32'd0);
    wait_done(lat);
    check_eq("b2b.latency", 32'(lat), 32'(WIDTH));
    check_out("b2b_second", model(3'b100, 8'h0A, 8'h50));

    // async reset mid-SUB
    @(posedge clk);
    #1;
    start_op(3'b110, 8'h07, 8'h05);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid.busy", 32'(busy), 32'd0);
    check_eq("rst_mid.result", 32'(result), 32'd0);
    check_eq("rst_mid.carry", 32'(carry_out), 32'd0);
    check_eq("rst_mid.slice_aop", 32'(slice_aop), 32'd0);
    seen = 1'b0;
    repeat (WIDTH + 2) begin
      @(posedge clk);
      #1;
      seen = seen | done;
    end
    check_eq("rst_mid.no_done", 32'(seen), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("illegal_011", 3'b011, 8'h5A, 8'hC3);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      if (i % 8 == 0) ra = rb;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
